// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Holds the FSM state encoding and the default busy timeout.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIfBusy  = 2'd1,
        StMemBusy = 2'd2,
        StErr     = 2'd3
    } arb_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-access requests onto one single-port RAM.
// Data accesses win over fetches; a hung RAM parks the block in a sticky error state.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,

    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,

    output logic              stall_IF,
    output logic              stall_MEM,
    output logic              err
);

    localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic              busy;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A requester still holds req during its ready cycle; don't regrant it.
                if (mem_req && !mem_ready_q) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    we_d    = mem_we;
                    cnt_d   = '0;
                    state_d = StMemBusy;
                end else if (if_req && !if_ready_q) begin
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StIfBusy;
                end
            end
            StIfBusy: begin
                if (ram_ack) begin
                    if_rdata_d = ram_rdata;
                    if_ready_d = 1'b1;
                    state_d    = StIdle;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StMemBusy: begin
                if (ram_ack) begin
                    if (!we_q) begin
                        mem_rdata_d = ram_rdata;
                    end
                    mem_ready_d = 1'b1;
                    state_d     = StIdle;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StErr: begin
                state_d = StErr;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign busy      = (state_q == StIfBusy) || (state_q == StMemBusy);
    assign ram_req   = busy;
    // Keep a stale store flag from leaking onto the RAM bus while idle.
    assign ram_we    = we_q & busy;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_ready = mem_ready_q;
    assign err       = (state_q == StErr);
    assign stall_IF  = if_req & ~if_ready_q;
    assign stall_MEM = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected results,
// a monitor pops them on every ready pulse; a RAM model answers with random latency.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ready;
    logic [31:0] if_addr, if_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        ram_req, ram_we, ram_ack;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        stall_IF, stall_MEM, err;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack),
        .stall_IF  (stall_IF),
        .stall_MEM (stall_MEM),
        .err       (err)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference memory (expected contents) and the RAM model's own storage.
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] if_exp_q[$];
    logic [31:0] mem_exp_q[$];
    logic [31:0] ref_last_load  = 32'h0;
    logic [31:0] ref_last_fetch = 32'h0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ram_read(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
    endfunction

    task automatic push_fetch(input logic [31:0] a);
        ref_last_fetch = ref_read(a);
        if_exp_q.push_back(ref_last_fetch);
    endtask

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
        if (we) ref_mem[a] = d;
        else    ref_last_load = ref_read(a);
        mem_exp_q.push_back(ref_last_load);
    endtask

    // RAM responder: acks after a random 0..ack_delay_max wait in each access.
    bit          ack_en        = 1'b1;
    bit          spurious      = 1'b0;
    int unsigned ack_delay_max = 0;

    initial begin
        int unsigned wait_cnt;
        int unsigned this_delay;
        wait_cnt   = 0;
        this_delay = 0;
        ram_ack    = 1'b0;
        ram_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            ram_ack = 1'b0;
            if (rst || !ram_req) begin
                wait_cnt   = 0;
                this_delay = $urandom_range(ack_delay_max, 0);
                if (spurious && !rst) begin
                    ram_ack   = 1'b1;
                    ram_rdata = 32'hBADC_0DE5;
                end
            end else if (ack_en) begin
                if (wait_cnt >= this_delay) begin
                    ram_ack = 1'b1;
                    if (ram_we) ram_mem[ram_addr] = ram_wdata;
                    else        ram_rdata = ram_read(ram_addr);
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: every ready pulse must match the oldest expectation.
    int unsigned if_ready_cnt  = 0;
    int unsigned mem_ready_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (if_ready) begin
                if_ready_cnt++;
                if (if_exp_q.size() == 0) check("if_ready_unexpected", if_ready, 1'b0);
                else                      check("if_rdata", if_rdata, if_exp_q.pop_front());
            end
            if (mem_ready) begin
                mem_ready_cnt++;
                if (mem_exp_q.size() == 0) check("mem_ready_unexpected", mem_ready, 1'b0);
                else                       check("mem_rdata", mem_rdata, mem_exp_q.pop_front());
            end
        end
    end

    // Requester tasks are entered on a falling edge and return on one.
    task automatic do_fetch(input logic [31:0] a);
        int n;
        push_fetch(a);
        if_addr = a;
        if_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_ready && n < 64);
        if (!if_ready) check("fetch_wait_bound", if_ready, 1'b1);
        if_req = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        push_mem(we, a, d);
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = d;
        mem_req   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 64);
        if (!mem_ready) check("mem_wait_bound", mem_ready, 1'b1);
        mem_req = 1'b0;
    endtask

    // Fetch with zero-wait RAM: ready must appear in the third cycle.
    task automatic fetch_timed(input logic [31:0] a);
        push_fetch(a);
        if_addr = a;
        if_req  = 1'b1;
        @(posedge clk); #1;
        check("ft_c2_ram_req", ram_req, 1'b1);
        check("ft_c2_ram_addr", ram_addr, a);
        check("ft_c2_ram_we", ram_we, 1'b0);
        check("ft_c2_if_ready", if_ready, 1'b0);
        check("ft_c2_stall_IF", stall_IF, 1'b1);
        @(posedge clk); #1;
        check("ft_c3_if_ready", if_ready, 1'b1);
        check("ft_c3_if_rdata", if_rdata, ref_last_fetch);
        check("ft_c3_stall_IF", stall_IF, 1'b0);
        @(negedge clk);
        if_req = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int          n;
        int          mem_at, if_at;
        bit          early, any_req;
        int unsigned cnt0;

        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        ram_mem[32'h100] = 32'h0050_0093;
        ref_mem[32'h100] = 32'h0050_0093;

        repeat (3) @(negedge clk);
        check("rst_ram_req", ram_req, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_if_ready", if_ready, 1'b0);
        check("rst_mem_ready", mem_ready, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic fetch of 0x100.
        fetch_timed(32'h100);
        check("fetch_100_data", if_rdata, 32'h0050_0093);

        // Simultaneous load and fetch: load is granted first.
        push_mem(1'b0, 32'h2000, 32'h0);
        push_fetch(32'h104);
        mem_we   = 1'b0;
        mem_addr = 32'h2000;
        mem_req  = 1'b1;
        if_addr  = 32'h104;
        if_req   = 1'b1;
        @(posedge clk); #1;
        check("prio_ram_addr", ram_addr, 32'h2000);
        check("prio_ram_req", ram_req, 1'b1);
        mem_at = -1;
        if_at  = -1;
        early  = 1'b0;
        n      = 0;
        while ((mem_at < 0 || if_at < 0) && n < 64) begin
            @(negedge clk);
            n++;
            if (mem_at < 0 && ram_req && ram_addr == 32'h104) early = 1'b1;
            if (mem_ready) begin mem_at = n; mem_req = 1'b0; end
            if (if_ready)  begin if_at = n;  if_req = 1'b0;  end
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
        check("prio_both_done", (mem_at >= 0) && (if_at >= 0), 1'b1);
        check("prio_mem_first", mem_at < if_at, 1'b1);
        check("prio_no_early_fetch", early, 1'b0);

        // Store: RAM sees the write, load data is untouched, exactly one ready.
        @(negedge clk);
        cnt0 = mem_ready_cnt;
        push_mem(1'b1, 32'h2004, 32'hDEAD_BEEF);
        mem_we    = 1'b1;
        mem_addr  = 32'h2004;
        mem_wdata = 32'hDEAD_BEEF;
        mem_req   = 1'b1;
        @(posedge clk); #1;
        check("st_ram_we", ram_we, 1'b1);
        check("st_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        check("st_ram_addr", ram_addr, 32'h2004);
        check("st_stall_MEM", stall_MEM, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 64);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("st_one_ready", mem_ready_cnt - cnt0, 1);
        check("st_rdata_kept", mem_rdata, init_val(32'h2000));
        @(negedge clk);
        do_mem(1'b0, 32'h2004, 32'h0);

        // Spurious ack while idle.
        @(posedge clk); #1;
        spurious = 1'b1;
        @(posedge clk); #1;
        spurious = 1'b0;
        check("sp_if_ready", if_ready, 1'b0);
        check("sp_mem_ready", mem_ready, 1'b0);
        check("sp_ram_req", ram_req, 1'b0);
        check("sp_if_rdata", if_rdata, ref_last_fetch);
        check("sp_mem_rdata", mem_rdata, ref_last_load);
        @(posedge clk); #1;
        check("sp_still_idle", ram_req, 1'b0);
        @(negedge clk);
        fetch_timed(32'h108);

        // Randomised traffic from both requesters with variable RAM latency.
        @(posedge clk); #1;
        ack_delay_max = 3;
        @(negedge clk);
        fork
            begin
                repeat (40) begin
                    repeat ($urandom_range(3, 0)) @(negedge clk);
                    do_fetch(32'h100 + 4 * $urandom_range(15, 0));
                end
            end
            begin
                repeat (40) begin
                    repeat ($urandom_range(3, 0)) @(negedge clk);
                    do_mem(1'($urandom_range(1, 0)), 32'h2000 + 4 * $urandom_range(15, 0),
                           $urandom);
                end
            end
        join
        repeat (5) @(negedge clk);
        #1;
        check("rand_if_q_empty", if_exp_q.size(), 0);
        check("rand_mem_q_empty", mem_exp_q.size(), 0);

        // Reset while a load is in flight.
        @(posedge clk); #1;
        ack_delay_max = 0;
        ack_en        = 1'b0;
        @(negedge clk);
        mem_we   = 1'b0;
        mem_addr = 32'h2008;
        mem_req  = 1'b1;
        @(posedge clk); #1;
        check("rb_busy", ram_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rb_ram_req_async", ram_req, 1'b0);
        check("rb_mem_ready", mem_ready, 1'b0);
        check("rb_mem_rdata", mem_rdata, 32'h0);
        check("rb_if_rdata", if_rdata, 32'h0);
        ref_last_load  = 32'h0;
        ref_last_fetch = 32'h0;
        @(negedge clk);
        mem_req = 1'b0;
        rst     = 1'b0;
        @(posedge clk); #1;
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
        fetch_timed(32'h10C);

        // Withheld ack: error after 16 busy cycles, sticky until reset.
        @(posedge clk); #1;
        ack_en = 1'b0;
        @(negedge clk);
        mem_we   = 1'b0;
        mem_addr = 32'h200C;
        mem_req  = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            if (ram_req) n++;
        end while (ram_req && n < 64);
        check("to_busy_cycles", n, 16);
        check("to_err", err, 1'b1);
        check("to_ram_req", ram_req, 1'b0);
        @(negedge clk);
        cnt0     = if_ready_cnt + mem_ready_cnt;
        if_addr  = 32'h100;
        if_req   = 1'b1;
        any_req  = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ram_req) any_req = 1'b1;
        end
        check("to_no_grant", any_req, 1'b0);
        check("to_err_sticky", err, 1'b1);
        check("to_no_ready", if_ready_cnt + mem_ready_cnt - cnt0, 0);
        @(negedge clk);
        if_req  = 1'b0;
        mem_req = 1'b0;
        rst     = 1'b1;
        #1;
        check("to_err_cleared", err, 1'b0);
        ref_last_load  = 32'h0;
        ref_last_fetch = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        ack_en = 1'b1;
        @(negedge clk);
        fetch_timed(32'h100);

        repeat (3) @(negedge clk);
        #1;
        check("end_if_q_empty", if_exp_q.size(), 0);
        check("end_mem_q_empty", mem_exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL declare parameter ADDR_W, default 32, byte address width.
REQ-002 The block SHALL declare parameter DATA_W, default 32, data width.
REQ-003 The block SHALL declare parameter TIMEOUT, default 16, maximum busy cycles without ram_ack before error.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 The block SHALL have port if_req, input, 1, fetch request, held until if_ready.
REQ-007 The block SHALL have port if_addr, input, ADDR_W, fetch address.
REQ-008 The block SHALL have port if_rdata, output, DATA_W, fetched instruction, registered.
REQ-009 The block SHALL have port if_ready, output, 1, one-cycle fetch completion pulse.
REQ-010 The block SHALL have port mem_req, input, 1, data-access request, held until mem_ready.
REQ-011 The block SHALL have port mem_we, input, 1, store when 1, load when 0.
REQ-012 The block SHALL have ports mem_addr (input, ADDR_W) and mem_wdata (input, DATA_W), data-access address and store data.
REQ-013 The block SHALL have port mem_rdata, output, DATA_W, load data, registered.
REQ-014 The block SHALL have port mem_ready, output, 1, one-cycle data-access completion pulse.
REQ-015 The block SHALL have ports ram_req, ram_we, ram_addr and ram_wdata, outputs (1, 1, ADDR_W and DATA_W), driving the shared single-port memory.
REQ-016 The block SHALL have ports ram_rdata (input, DATA_W) and ram_ack (input, 1, one-cycle completion).
REQ-017 The block SHALL have ports stall_IF and stall_MEM, outputs, 1, stall requests to the hazard unit.
REQ-018 The block SHALL have port err, output, 1, sticky timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, IF_BUSY, MEM_BUSY and ERR.
REQ-020 In IDLE with mem_req=1, the block SHALL latch mem_addr, mem_wdata and mem_we and go to MEM_BUSY; MEM has priority over IF.
REQ-021 In IDLE with mem_req=0 and if_req=1, the block SHALL latch if_addr, set the latched we to 0 and go to IF_BUSY.
REQ-022 In IF_BUSY and MEM_BUSY, ram_req SHALL be 1 and ram_addr, ram_we and ram_wdata SHALL be the latched values, stable until ack.
REQ-023 On ram_ack in IF_BUSY, the block SHALL capture ram_rdata into if_rdata, pulse if_ready for the next cycle and return to IDLE.
REQ-024 On ram_ack in MEM_BUSY, the block SHALL pulse mem_ready for the next cycle, capture ram_rdata into mem_rdata only for loads, and return to IDLE.
REQ-025 Minimum access latency SHALL be 3 cycles from request to ready, assuming ram_ack arrives in the first busy cycle.
REQ-026 A ram_ack received in IDLE or ERR SHALL be ignored.
REQ-027 A 0..TIMEOUT-1 busy counter SHALL clear on entering a busy state and increment each busy cycle without ack; reaching TIMEOUT-1 without ack SHALL move the FSM to ERR.
REQ-028 In ERR, ram_req SHALL be 0, err SHALL be 1, no grants SHALL occur, and the FSM SHALL leave ERR only on reset.
REQ-029 stall_IF SHALL be if_req & ~if_ready, and stall_MEM SHALL be mem_req & ~mem_ready; both combinational.
REQ-030 A requester deasserting req before ready SHALL NOT abort an access already in progress; its ready pulse SHALL still occur.

Reset
REQ-031 On rst=1, the FSM SHALL be IDLE, the counter 0, and ram_req, ram_we, if_ready, mem_ready and err 0, immediately (asynchronously).
REQ-032 On rst=1, ram_addr, ram_wdata, if_rdata and mem_rdata SHALL be 0.
REQ-033 A reset during a busy state SHALL abandon the access with no ready pulse.

Structure
REQ-034 The FSM state encoding and the TIMEOUT default SHALL live in shared package mem_arb_pkg.
REQ-035 The block SHALL be a single module with no sub-modules.

Verification
REQ-036 The bench SHALL drive if_req with if_addr=0x100 and ram_ack one cycle after ram_req with rdata=0x00500093, and SHALL check if_ready on cycle 3 with if_rdata=0x00500093.
REQ-037 The bench SHALL assert if_req and mem_req (load, 0x2000) in the same cycle, and SHALL check that ram_addr=0x2000 is granted first and the fetch only after mem_ready.
REQ-038 The bench SHALL run a store with mem_wdata=0xDEADBEEF and mem_we=1, and SHALL check ram_we=1 and ram_wdata=0xDEADBEEF, mem_rdata unchanged, and one mem_ready pulse.
REQ-039 The bench SHALL withhold ram_ack with TIMEOUT=16, and SHALL check ERR entered after 16 busy cycles, err=1, ram_req=0, with later requests ignored until rst.
REQ-040 The bench SHALL assert rst in MEM_BUSY, and SHALL check that ram_req falls before the next clock edge, with no mem_ready, the FSM in IDLE, and a subsequent fetch completing normally.
REQ-041 The bench SHALL drive a spurious ram_ack in IDLE, and SHALL check that there is no ready pulse and no state change.
